mips_test_sequencer: RTL and testbench

- Synthesizable, parametrised test harness for the MIPS core.
- Copies a program image from a source ROM into the core's instruction memory.
- Runs the core for a programmed number of clock-enabled cycles, then checks the register file against an expected-value ROM.
- Reports pass/fail, a mismatch count and the first failing register. The block sits beside mips_core and replaces hand-poked memories and off-line dump comparison.

---
 rtl/mips_test_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mips_test_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_test_sequencer.sv
// mips_test_sequencer: copies a program ROM into the MIPS core's imem, steps the core, then checks its register file.
// Latency: start to done = 1 + (num_instr ? num_instr+1 : 0) + run_cycles + REG_COUNT + 2 cycles.
// Backpressure: none; start is a one-cycle request taken only in IDLE and ignored while busy.
//
// Ports:
//   clock, reset_n            : rising-edge clock, asynchronous active-low reset
//   start, num_instr,
//   run_cycles, check_mask    : job request and its parameters, latched when start is accepted
//   rom_addr / rom_data       : program ROM read port (data one cycle after address)
//   imem_we/addr/wdata        : instruction memory write port
//   core_en                   : core clock-enable, high only while running the program
//   rf_raddr / rf_rdata       : register file read port (combinational read)
//   exp_addr / exp_data       : expected-value ROM read port (data one cycle after address)
//   busy, done, pass,
//   fail_count, first_fail_*  : status and result, results held until the next accepted start
module mips_test_sequencer #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMEM_ADDR_WIDTH = 5,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int REG_COUNT       = 32,
   parameter int CYCLE_WIDTH     = 16,
   parameter int FAIL_WIDTH      = 6
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [IMEM_ADDR_WIDTH:0]   num_instr,
   input  logic [CYCLE_WIDTH-1:0]     run_cycles,
   input  logic [REG_COUNT-1:0]       check_mask,
   output logic [IMEM_ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0]      rom_data,
   output logic                       imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0]      imem_wdata,
   output logic                       core_en,
   output logic [REG_ADDR_WIDTH-1:0]  rf_raddr,
   input  logic [DATA_WIDTH-1:0]      rf_rdata,
   output logic [REG_ADDR_WIDTH-1:0]  exp_addr,
   input  logic [DATA_WIDTH-1:0]      exp_data,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [FAIL_WIDTH-1:0]      fail_count,
   output logic [REG_ADDR_WIDTH-1:0]  first_fail_reg,
   output logic                       first_fail_valid
);

   localparam int LW = IMEM_ADDR_WIDTH + 1;
   localparam int CW = REG_ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CHK_LAST = CW'(REG_COUNT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      CHECK  = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t                     state;
   logic [LW-1:0]              num_q;
   logic [REG_COUNT-1:0]       mask_q;
   logic [LW-1:0]              ld_cnt;    // LOAD cycle index, one wider than imem address so depth never wraps
   logic [CYCLE_WIDTH-1:0]     run_cnt;   // holds run_cycles until RUN, then counts down remaining core_en cycles
   logic [CW-1:0]              chk_cnt;   // CHECK cycle index 0..REG_COUNT
   logic [DATA_WIDTH-1:0]      rf_q;      // register value read in the previous CHECK cycle
   logic [REG_ADDR_WIDTH-1:0]  cmp_idx;   // register index that rf_q belongs to
   logic                       cmp_vld;   // rf_q / exp_data hold a pair to compare this cycle

   logic [LW-1:0]              ld_nxt;
   logic [CW-1:0]              chk_nxt;
   logic                       mism;
   logic [FAIL_WIDTH-1:0]      fail_nxt;

   always_comb begin
      ld_nxt   = ld_cnt + LW'(1);
      chk_nxt  = chk_cnt + CW'(1);
      mism     = cmp_vld && mask_q[cmp_idx] && (rf_q != exp_data);
      fail_nxt = fail_count;
      if (mism && (fail_count != '1)) begin
         fail_nxt = fail_count + FAIL_WIDTH'(1);
      end
   end

   // ROM data arrives the cycle after its address, which is exactly the cycle
   // imem_we is high for that word, so the data is forwarded rather than registered.
   assign imem_wdata = imem_we ? rom_data : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         num_q            <= '0;
         mask_q           <= '0;
         ld_cnt           <= '0;
         run_cnt          <= '0;
         chk_cnt          <= '0;
         rf_q             <= '0;
         cmp_idx          <= '0;
         cmp_vld          <= 1'b0;
         rom_addr         <= '0;
         imem_we          <= 1'b0;
         imem_addr        <= '0;
         core_en          <= 1'b0;
         rf_raddr         <= '0;
         exp_addr         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         fail_count       <= '0;
         first_fail_reg   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  num_q            <= num_instr;
                  mask_q           <= check_mask;
                  run_cnt          <= run_cycles;
                  ld_cnt           <= '0;
                  chk_cnt          <= '0;
                  cmp_vld          <= 1'b0;
                  pass             <= 1'b0;
                  fail_count       <= '0;
                  first_fail_reg   <= '0;
                  first_fail_valid <= 1'b0;
                  busy             <= 1'b1;
                  // rom_addr, rf_raddr and exp_addr are already 0 outside their phases
                  if (num_instr != '0) begin
                     state <= LOAD;
                  end else if (run_cycles != '0) begin
                     state   <= RUN;
                     core_en <= 1'b1;
                  end else begin
                     state <= CHECK;
                  end
               end
            end

            LOAD: begin
               ld_cnt <= ld_nxt;
               if (ld_cnt == num_q) begin
                  // last LOAD cycle: final write is on the bus now
                  imem_we   <= 1'b0;
                  imem_addr <= '0;
                  rom_addr  <= '0;
                  if (run_cnt != '0) begin
                     state   <= RUN;
                     core_en <= 1'b1;
                  end else begin
                     state <= CHECK;
                  end
               end else begin
                  imem_we   <= 1'b1;
                  imem_addr <= ld_cnt[IMEM_ADDR_WIDTH-1:0];
                  rom_addr  <= (ld_nxt < num_q) ? ld_nxt[IMEM_ADDR_WIDTH-1:0] : '0;
               end
            end

            RUN: begin
               if (run_cnt == CYCLE_WIDTH'(1)) begin
                  core_en <= 1'b0;
                  run_cnt <= '0;
                  state   <= CHECK;
               end else begin
                  run_cnt <= run_cnt - CYCLE_WIDTH'(1);
               end
            end

            CHECK: begin
               chk_cnt    <= chk_nxt;
               fail_count <= fail_nxt;
               if (mism && !first_fail_valid) begin
                  first_fail_reg   <= cmp_idx;
                  first_fail_valid <= 1'b1;
               end
               if (chk_cnt == CHK_LAST) begin
                  // drain cycle: last compare happens now, result is final
                  cmp_vld  <= 1'b0;
                  rf_raddr <= '0;
                  exp_addr <= '0;
                  done     <= 1'b1;
                  pass     <= (fail_nxt == '0);
                  state    <= FINISH;
               end else begin
                  rf_q     <= rf_rdata;
                  cmp_idx  <= chk_cnt[REG_ADDR_WIDTH-1:0];
                  cmp_vld  <= 1'b1;
                  rf_raddr <= (chk_nxt < CHK_LAST) ? chk_nxt[REG_ADDR_WIDTH-1:0] : '0;
                  exp_addr <= (chk_nxt < CHK_LAST) ? chk_nxt[REG_ADDR_WIDTH-1:0] : '0;
               end
            end

            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_test_sequencer.sv
// tb_mips_test_sequencer: directed bench for mips_test_sequencer with ROM/imem/regfile models.
// A second instance with a 2-bit fail counter runs in lockstep to observe saturation.
module tb_mips_test_sequencer;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [5:0]  num_instr;
   logic [15:0] run_cycles;
   logic [31:0] check_mask;

   logic [4:0]  rom_addr, imem_addr, rf_raddr, exp_addr, first_fail_reg;
   logic [31:0] rom_data, imem_wdata, rf_rdata, exp_data;
   logic        imem_we, core_en, busy, done, pass, first_fail_valid;
   logic [5:0]  fail_count;

   logic [4:0]  rom_addr_s, imem_addr_s, rf_raddr_s, exp_addr_s, first_fail_reg_s;
   logic [31:0] rom_data_s, imem_wdata_s, rf_rdata_s, exp_data_s;
   logic        imem_we_s, core_en_s, busy_s, done_s, pass_s, first_fail_valid_s;
   logic [1:0]  fail_count_s;

   logic [31:0] prog_rom [32];
   logic [31:0] imem     [32];
   logic [31:0] rf       [32];
   logic [31:0] exp_rom  [32];

   int n_chk = 0;
   int n_err = 0;
   int we_tot = 0, en_tot = 0, en_rise = 0, done_tot = 0, bad_wr = 0, sat_diff = 0;
   logic       prev_we = 1'b0, prev_en = 1'b0;
   logic [4:0] prev_addr = '0;

   mips_test_sequencer u_dut (
      .clock(clock), .reset_n(reset_n), .start(start), .num_instr(num_instr),
      .run_cycles(run_cycles), .check_mask(check_mask),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_en(core_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .exp_addr(exp_addr), .exp_data(exp_data),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .first_fail_reg(first_fail_reg), .first_fail_valid(first_fail_valid)
   );

   mips_test_sequencer #(.FAIL_WIDTH(2)) u_sat (
      .clock(clock), .reset_n(reset_n), .start(start), .num_instr(num_instr),
      .run_cycles(run_cycles), .check_mask(check_mask),
      .rom_addr(rom_addr_s), .rom_data(rom_data_s),
      .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
      .core_en(core_en_s), .rf_raddr(rf_raddr_s), .rf_rdata(rf_rdata_s),
      .exp_addr(exp_addr_s), .exp_data(exp_data_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .fail_count(fail_count_s),
      .first_fail_reg(first_fail_reg_s), .first_fail_valid(first_fail_valid_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // synchronous ROMs with one cycle of read latency
   always @(posedge clock) begin
      rom_data   <= prog_rom[rom_addr];
      exp_data   <= exp_rom[exp_addr];
      rom_data_s <= prog_rom[rom_addr_s];
      exp_data_s <= exp_rom[exp_addr_s];
   end

   assign rf_rdata   = rf[rf_raddr];
   assign rf_rdata_s = rf[rf_raddr_s];

   // bus monitor, sampled mid-cycle
   always @(negedge clock) begin
      if (imem_we) begin
         we_tot++;
         if (prev_we ? (imem_addr != 5'(prev_addr + 5'd1)) : (imem_addr != 5'd0)) bad_wr++;
         if (imem_wdata != prog_rom[imem_addr]) bad_wr++;
         imem[imem_addr] = imem_wdata;
      end
      if (core_en) begin
         en_tot++;
         if (!prev_en) en_rise++;
      end
      if (done) done_tot++;
      if ({busy_s, done_s, imem_we_s, core_en_s, rom_addr_s, imem_addr_s, rf_raddr_s, exp_addr_s, imem_wdata_s} !=
          {busy,   done,   imem_we,   core_en,   rom_addr,   imem_addr,   rf_raddr,   exp_addr,   imem_wdata})
         sat_diff++;
      prev_we   = imem_we;
      prev_addr = imem_addr;
      prev_en   = core_en;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   // Pulse start, wait (bounded) for done, return start-cycle-inclusive latency or -1.
   // A nonzero inject cycle drives a second, conflicting start while busy.
   task automatic run_test(input logic [5:0] n, input logic [15:0] r, input logic [31:0] m,
                           input int inject, output int lat);
      int cyc;
      @(negedge clock);
      num_instr = n; run_cycles = r; check_mask = m; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 2;
      while (!done && cyc < 400) begin
         if (cyc == inject) begin
            start = 1'b1; num_instr = 6'd7; run_cycles = 16'd200; check_mask = 32'h0;
         end else if (cyc == inject + 1) begin
            start = 1'b0;
         end
         @(negedge clock);
         cyc++;
      end
      lat = done ? cyc : -1;
      check_val("busy_at_done", {31'd0, busy}, 32'd1);
      @(negedge clock);
      check_val("done_one_cycle", {31'd0, done}, 32'd0);
      check_val("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, we0, en0, rise0, done0, bad0;
      reset_n = 1'b0; start = 1'b0; num_instr = '0; run_cycles = '0; check_mask = '0;
      for (int i = 0; i < 32; i++) begin
         prog_rom[i] = 32'hA500_0000 | 32'(i * 257);
         exp_rom[i]  = 32'h1234_0000 + 32'(i * 7);
         rf[i]       = exp_rom[i];
      end

      // reset state
      @(negedge clock); @(negedge clock);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_pass", {31'd0, pass}, 32'd0);
      check_val("rst_fail_count", {26'd0, fail_count}, 32'd0);
      check_val("rst_ffv", {31'd0, first_fail_valid}, 32'd0);
      check_val("rst_strobes", {30'd0, imem_we, core_en}, 32'd0);
      check_val("rst_addrs", {17'd0, rom_addr, imem_addr, rf_raddr}, 32'd0);
      reset_n = 1'b1;

      // load 18 words, no run, nothing checked
      we0 = we_tot; en0 = en_tot; bad0 = bad_wr;
      run_test(6'd18, 16'd0, 32'h0, 0, lat);
      check_val("load18_latency", lat, 32'd54);
      check_val("load18_we_count", we_tot - we0, 32'd18);
      check_val("load18_wr_order_data", bad_wr - bad0, 32'd0);
      check_val("load18_imem0", imem[0], prog_rom[0]);
      check_val("load18_imem17", imem[17], prog_rom[17]);
      check_val("load18_no_core_en", en_tot - en0, 32'd0);
      check_val("load18_pass", {31'd0, pass}, 32'd1);

      // run only
      we0 = we_tot; en0 = en_tot; rise0 = en_rise;
      run_test(6'd0, 16'd17, 32'h0, 0, lat);
      check_val("run17_latency", lat, 32'd52);
      check_val("run17_no_we", we_tot - we0, 32'd0);
      check_val("run17_en_cycles", en_tot - en0, 32'd17);
      check_val("run17_en_bursts", en_rise - rise0, 32'd1);

      // all registers match
      run_test(6'd0, 16'd0, 32'hFFFF_FFFF, 0, lat);
      check_val("match_latency", lat, 32'd35);
      check_val("match_pass", {31'd0, pass}, 32'd1);
      check_val("match_fail_count", {26'd0, fail_count}, 32'd0);
      check_val("match_ffv", {31'd0, first_fail_valid}, 32'd0);

      // mismatches at 5 and 29
      rf[5]  = exp_rom[5] ^ 32'h1;
      rf[29] = exp_rom[29] ^ 32'h8000_0000;
      run_test(6'd0, 16'd0, 32'hFFFF_FFFF, 0, lat);
      check_val("mm2_pass", {31'd0, pass}, 32'd0);
      check_val("mm2_fail_count", {26'd0, fail_count}, 32'd2);
      check_val("mm2_first_reg", {27'd0, first_fail_reg}, 32'd5);
      check_val("mm2_ffv", {31'd0, first_fail_valid}, 32'd1);
      repeat (3) @(negedge clock);
      check_val("mm2_hold_count", {26'd0, fail_count}, 32'd2);
      check_val("mm2_hold_reg", {27'd0, first_fail_reg}, 32'd5);

      // bit 5 masked
      run_test(6'd0, 16'd0, 32'hFFFF_FFDF, 0, lat);
      check_val("mask5_fail_count", {26'd0, fail_count}, 32'd1);
      check_val("mask5_first_reg", {27'd0, first_fail_reg}, 32'd29);
      check_val("mask5_pass", {31'd0, pass}, 32'd0);

      // five mismatches: saturation of the 2-bit counter
      for (int i = 0; i < 32; i++) rf[i] = exp_rom[i];
      rf[1] = ~exp_rom[1]; rf[2] = ~exp_rom[2]; rf[3] = ~exp_rom[3];
      rf[10] = ~exp_rom[10]; rf[31] = ~exp_rom[31];
      run_test(6'd0, 16'd0, 32'hFFFF_FFFF, 0, lat);
      check_val("mm5_fail_count", {26'd0, fail_count}, 32'd5);
      check_val("mm5_sat_fail_count", {30'd0, fail_count_s}, 32'd3);
      check_val("mm5_sat_first_reg", {27'd0, first_fail_reg_s}, 32'd1);
      check_val("mm5_sat_pass", {31'd0, pass_s}, 32'd0);
      for (int i = 0; i < 32; i++) rf[i] = exp_rom[i];

      // reset asserted during RUN
      @(negedge clock);
      num_instr = 6'd2; run_cycles = 16'd100; check_mask = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (6) @(negedge clock);
      check_val("abort_core_en_running", {31'd0, core_en}, 32'd1);
      check_val("abort_count_cleared", {26'd0, fail_count}, 32'd0);
      reset_n = 1'b0;
      #1;
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_strobes", {29'd0, imem_we, core_en, done}, 32'd0);
      check_val("abort_result", {23'd0, pass, fail_count, first_fail_reg}, 32'd0);
      we0 = we_tot; en0 = en_tot;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      check_val("abort_idle_after_release", {31'd0, busy}, 32'd0);
      check_val("abort_no_activity", (we_tot - we0) + (en_tot - en0), 32'd0);

      // full-depth load, with a start pulse injected while busy
      we0 = we_tot; en0 = en_tot; done0 = done_tot; bad0 = bad_wr;
      run_test(6'd32, 16'd3, 32'hFFFF_FFFF, 10, lat);
      repeat (4) @(negedge clock);
      check_val("depth_latency", lat, 32'd71);
      check_val("depth_we_count", we_tot - we0, 32'd32);
      check_val("depth_wr_order_data", bad_wr - bad0, 32'd0);
      check_val("depth_imem31", imem[31], prog_rom[31]);
      check_val("depth_en_cycles", en_tot - en0, 32'd3);
      check_val("depth_single_done", done_tot - done0, 32'd1);
      check_val("depth_pass", {31'd0, pass}, 32'd1);
      check_val("depth_idle", {31'd0, busy}, 32'd0);

      check_val("lockstep_sat_instance", sat_diff, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
